// File: rtl/tam_pkg.sv
// Shared FSM encoding, default configuration and sizing helpers for the
// toggle activity monitor.
package tam_pkg;

  localparam int DEF_DATA_W  = 4;
  localparam int DEF_WIN_LEN = 16;
  localparam int DEF_ACC_W   = 16;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_PRIME  = 2'd1,
    ST_ACCUM  = 2'd2,
    ST_REPORT = 2'd3
  } tam_state_e;

  // Width needed to hold a Hamming distance of 0..data_w.
  function automatic int peak_width(input int data_w);
    return $clog2(data_w + 1);
  endfunction

  // Width needed to hold a transition count of 0..win_len.
  function automatic int cnt_width(input int win_len);
    return $clog2(win_len + 1);
  endfunction

  localparam int PEAK_W = peak_width(DEF_DATA_W);
  localparam int CNT_W  = cnt_width(DEF_WIN_LEN);

endpackage

// File: rtl/popcount.sv
// Combinational Hamming distance between two DATA_W-bit words.
module popcount #(
  parameter int DATA_W = 4,
  parameter int OUT_W  = $clog2(DATA_W + 1)
) (
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic [OUT_W-1:0]  count
);

  logic [DATA_W-1:0] diff;

  assign diff = a ^ b;

  // NOTE: combinational blocks use blocking '=' so the running sum is read back
  // within the same pass; clocked blocks use '<=' so all flops update together.
  always_comb begin
    count = '0;
    for (int i = 0; i < DATA_W; i++) begin
      count = count + OUT_W'(diff[i]);
    end
  end

endmodule

// File: rtl/toggle_activity_monitor.sv
// Measures bus switching activity over a window of WIN_LEN transitions and
// presents total toggles, peak and saturation over a valid/ready handshake.
module toggle_activity_monitor
  import tam_pkg::*;
#(
  parameter int DATA_W  = DEF_DATA_W,
  parameter int WIN_LEN = DEF_WIN_LEN,
  parameter int ACC_W   = DEF_ACC_W
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          clear,
  input  logic                          start,
  input  logic                          in_valid,
  input  logic [DATA_W-1:0]             in_data,
  output logic                          busy,
  output logic                          res_valid,
  input  logic                          res_ready,
  output logic [ACC_W-1:0]              res_toggles,
  output logic [peak_width(DATA_W)-1:0] res_peak,
  output logic                          res_sat
);

  localparam int HD_W   = peak_width(DATA_W);
  localparam int TCNT_W = cnt_width(WIN_LEN);

  tam_state_e        state_q, state_d;
  logic [DATA_W-1:0] prev_q, prev_d;
  logic [ACC_W-1:0]  acc_q, acc_d;
  logic [HD_W-1:0]   peak_q, peak_d;
  logic              sat_q, sat_d;
  logic [TCNT_W-1:0] cnt_q, cnt_d;
  logic [ACC_W-1:0]  res_toggles_q, res_toggles_d;
  logic [HD_W-1:0]   res_peak_q, res_peak_d;
  logic              res_sat_q, res_sat_d;

  logic [HD_W-1:0]   hd;
  logic [ACC_W:0]    acc_sum;
  logic [ACC_W-1:0]  acc_upd;
  logic [HD_W-1:0]   peak_upd;
  logic              sat_upd;
  logic              last_trans;

  popcount #(
    .DATA_W (DATA_W),
    .OUT_W  (HD_W)
  ) u_popcount (
    .a     (in_data),
    .b     (prev_q),
    .count (hd)
  );

  // One spare carry bit detects overflow; the accumulator then pins at all-ones.
  always_comb begin
    acc_sum    = {1'b0, acc_q} + (ACC_W + 1)'(hd);
    acc_upd    = acc_sum[ACC_W] ? '1 : acc_sum[ACC_W-1:0];
    sat_upd    = sat_q | acc_sum[ACC_W];
    peak_upd   = (hd > peak_q) ? hd : peak_q;
    last_trans = (cnt_q == TCNT_W'(WIN_LEN - 1));
  end

  // NOTE: every always_comb output gets a default first, so no path through the
  // case leaves a signal unassigned and no latch is inferred.
  always_comb begin
    state_d       = state_q;
    prev_d        = prev_q;
    acc_d         = acc_q;
    peak_d        = peak_q;
    sat_d         = sat_q;
    cnt_d         = cnt_q;
    res_toggles_d = res_toggles_q;
    res_peak_d    = res_peak_q;
    res_sat_d     = res_sat_q;

    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_PRIME;
          acc_d   = '0;
          peak_d  = '0;
          sat_d   = 1'b0;
          cnt_d   = '0;
        end
      end
      ST_PRIME: begin
        if (in_valid) begin
          prev_d  = in_data;
          state_d = ST_ACCUM;
        end
      end
      ST_ACCUM: begin
        if (in_valid) begin
          acc_d  = acc_upd;
          sat_d  = sat_upd;
          peak_d = peak_upd;
          prev_d = in_data;
          cnt_d  = cnt_q + TCNT_W'(1);
          if (last_trans) begin
            state_d       = ST_REPORT;
            res_toggles_d = acc_upd;
            res_peak_d    = peak_upd;
            res_sat_d     = sat_upd;
          end
        end
      end
      ST_REPORT: begin
        if (res_ready) begin
          if (start) begin
            state_d = ST_PRIME;
            acc_d   = '0;
            peak_d  = '0;
            sat_d   = 1'b0;
            cnt_d   = '0;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (clear) begin
      state_d = ST_IDLE;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= ST_IDLE;
      prev_q        <= '0;
      acc_q         <= '0;
      peak_q        <= '0;
      sat_q         <= 1'b0;
      cnt_q         <= '0;
      res_toggles_q <= '0;
      res_peak_q    <= '0;
      res_sat_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      prev_q        <= prev_d;
      acc_q         <= acc_d;
      peak_q        <= peak_d;
      sat_q         <= sat_d;
      cnt_q         <= cnt_d;
      res_toggles_q <= res_toggles_d;
      res_peak_q    <= res_peak_d;
      res_sat_q     <= res_sat_d;
    end
  end

  assign busy        = (state_q == ST_PRIME) || (state_q == ST_ACCUM);
  assign res_valid   = (state_q == ST_REPORT);
  assign res_toggles = res_toggles_q;
  assign res_peak    = res_peak_q;
  assign res_sat     = res_sat_q;

endmodule
